// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RNBIP-2 program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMWAIT,
    ST_HALT
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JCC  = 3'd2;
  localparam logic [2:0] OP_JMPR = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam logic [1:0] PC_R0   = 2'b00;
  localparam logic [1:0] PC_DM   = 2'b01;
  localparam logic [1:0] PC_OR2  = 2'b10;
  localparam logic [1:0] PC_IDLE = 2'b11;

  localparam int WDOG_MAX_DEF = 15;

endpackage

// File: rtl/pc_seq_watchdog.sv
// Counts consecutive enabled cycles; expire flags the WDOG_MAX-th one (a clear in that cycle wins).
module pc_seq_watchdog
  import pc_seq_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(WDOG_MAX - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (enable) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencing FSM: fetch/decode/return-wait/halt with watchdog-guarded DM returns.
// Optional `PC_SEQ_PERF_EN adds a 16-bit retired-instruction counter output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        instr_valid,
  input  logic [2:0]  op,
  input  logic        cond,
  input  logic        dm_ack,
  input  logic        resume,
  output logic        ir_ld,
  output logic        I_PC,
  output logic        L_PC,
  output logic        S11,
  output logic        S10,
  output logic        dm_rd,
  output logic        halted,
  output logic        fault
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0] retired
`endif
);

  state_t     state;
  logic       fault_q;
  logic       wd_expire;
  logic [1:0] sel;

  pc_seq_watchdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  ((state != ST_MEMWAIT) || dm_ack),
    .enable (state == ST_MEMWAIT),
    .expire (wd_expire)
  );

  // Strobes are decoded from the current state and inputs so the PC moves on the same edge that leaves DECODE.
  always_comb begin
    ir_ld = 1'b0;
    I_PC  = 1'b0;
    L_PC  = 1'b0;
    sel   = PC_IDLE;
    dm_rd = 1'b0;
    case (state)
      ST_FETCH:   ir_ld = instr_valid;
      ST_DECODE: begin
        case (op)
          OP_JMP: begin
            L_PC = 1'b1;
            sel  = PC_OR2;
          end
          OP_JCC: begin
            if (cond) begin
              L_PC = 1'b1;
              sel  = PC_OR2;
            end else begin
              I_PC = 1'b1;
            end
          end
          OP_JMPR: begin
            L_PC = 1'b1;
            sel  = PC_R0;
          end
          OP_RET, OP_HALT: ;
          default: I_PC = 1'b1;
        endcase
      end
      ST_MEMWAIT: begin
        dm_rd = 1'b1;
        if (dm_ack) begin
          L_PC = 1'b1;
          sel  = PC_DM;
        end
      end
      ST_HALT:    I_PC = resume && !fault_q;
      default: ;
    endcase
  end

  assign {S11, S10} = sel;
  assign halted     = (state == ST_HALT);
  assign fault      = fault_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (instr_valid) state <= ST_DECODE;
        ST_DECODE: begin
          case (op)
            OP_RET:  state <= ST_MEMWAIT;
            OP_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
          endcase
        end
        ST_MEMWAIT: begin
          if (dm_ack) begin
            state <= ST_FETCH;
          end else if (wd_expire) begin
            state   <= ST_HALT;
            fault_q <= 1'b1;
          end
        end
        ST_HALT: if (resume && !fault_q) state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      retired <= 16'd0;
    end else if (I_PC || L_PC) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: instruction-level driver pushes expected per-cycle outputs, negedge monitor compares.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int WD = 15;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        instr_valid, cond, dm_ack, resume;
  logic [2:0]  op;
  logic        ir_ld, I_PC, L_PC, S11, S10, dm_rd, halted, fault;
  logic [15:0] retired;

  pc_sequencer #(.WDOG_MAX(WD)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .instr_valid (instr_valid),
    .op          (op),
    .cond        (cond),
    .dm_ack      (dm_ack),
    .resume      (resume),
    .ir_ld       (ir_ld),
    .I_PC        (I_PC),
    .L_PC        (L_PC),
    .S11         (S11),
    .S10         (S10),
    .dm_rd       (dm_rd),
    .halted      (halted),
    .fault       (fault)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired     (retired)
`endif
  );

`ifndef PC_SEQ_PERF_EN
  assign retired = 16'd0;
`endif

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ir_ld;
    logic        i_pc;
    logic        l_pc;
    logic [1:0]  sel;
    logic        dm_rd;
    logic        halted;
    logic        fault;
    logic [15:0] retired;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic        fault_m = 1'b0;
  logic [15:0] ret_m = 16'd0;
  int          inc_m = 0;
  int          inc_obs = 0;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s got=%0d want=%0d", name, act, req);
  endtask

  // Monitor: every cycle with a queued expectation is compared at the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {ir_ld, I_PC, L_PC, S11, S10, dm_rd, halted, fault, retired};
        if (a.i_pc) inc_obs++;
        checks++;
        if (a === e) passes++;
        else $display("FAIL cycle%0d got ir=%b ip=%b lp=%b sel=%b dm=%b h=%b f=%b ret=%0d want ir=%b ip=%b lp=%b sel=%b dm=%b h=%b f=%b ret=%0d",
                      cyc, a.ir_ld, a.i_pc, a.l_pc, a.sel, a.dm_rd, a.halted, a.fault, a.retired,
                      e.ir_ld, e.i_pc, e.l_pc, e.sel, e.dm_rd, e.halted, e.fault, e.retired);
      end
    end
  end

  task automatic expect_cycle(input logic ir, input logic ip, input logic lp,
                              input logic [1:0] sel, input logic dm, input logic hl);
    obs_t e;
    e.ir_ld  = ir;
    e.i_pc   = ip;
    e.l_pc   = lp;
    e.sel    = sel;
    e.dm_rd  = dm;
    e.halted = hl;
    e.fault  = fault_m;
`ifdef PC_SEQ_PERF_EN
    e.retired = ret_m;
`else
    e.retired = 16'd0;
`endif
    exp_q.push_back(e);
    if (ip || lp) ret_m = ret_m + 16'd1;
    if (ip) inc_m++;
    @(posedge CLK);
    #1;
  endtask

  task automatic noise();
    cond   = 1'($urandom);
    dm_ack = 1'($urandom);
    resume = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    RST_N  = 1'b0;
    dm_ack = 1'b0;
    resume = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
    RST_N   = 1'b1;
    fault_m = 1'b0;
    ret_m   = 16'd0;
  endtask

  task automatic idle_cycle();
    instr_valid = 1'b0;
    op = 3'($urandom);
    noise();
    expect_cycle(0, 0, 0, PC_IDLE, 0, 0);
  endtask

  // One instruction: idle fetch cycles, fetch, decode, then any return wait and halt phases.
  // ack_at: MEMWAIT cycle (1-based) carrying dm_ack, 0 = never.
  task automatic run_instr(input logic [2:0] o, input logic c, input int idle,
                           input int ack_at, input int res_delay);
    logic do_load, do_inc, go_halt;
    for (int i = 0; i < idle; i++) idle_cycle();
    instr_valid = 1'b1;
    op = o;
    noise();
    expect_cycle(1, 0, 0, PC_IDLE, 0, 0);

    instr_valid = 1'($urandom);
    op = o;
    noise();
    cond = c;
    do_load = (o == OP_JMP) || (o == OP_JMPR) || (o == OP_JCC && c);
    do_inc  = (o == OP_ALU) || (o == OP_NOP) || (o == OP_RSV) || (o == OP_JCC && !c);
    expect_cycle(0, do_inc, do_load, do_load ? ((o == OP_JMPR) ? PC_R0 : PC_OR2) : PC_IDLE, 0, 0);

    go_halt = (o == OP_HALT);
    if (o == OP_RET) begin
      for (int k = 1; k <= WD; k++) begin
        instr_valid = 1'($urandom);
        op = 3'($urandom);
        resume = 1'($urandom);
        dm_ack = (k == ack_at);
        if (k == ack_at) begin
          expect_cycle(0, 0, 1, PC_DM, 1, 0);
          break;
        end
        expect_cycle(0, 0, 0, PC_IDLE, 1, 0);
        if (k == WD) begin
          fault_m = 1'b1;
          go_halt = 1'b1;
        end
      end
    end

    if (go_halt) begin
      instr_valid = 1'($urandom);
      if (fault_m) begin
        for (int i = 0; i < 4; i++) begin
          noise();
          resume = (i < 2) ? 1'b1 : 1'($urandom);
          expect_cycle(0, 0, 0, PC_IDLE, 0, 1);
        end
        do_reset(1);
      end else begin
        for (int i = 0; i < res_delay; i++) begin
          noise();
          resume = 1'b0;
          expect_cycle(0, 0, 0, PC_IDLE, 0, 1);
        end
        noise();
        resume = 1'b1;
        expect_cycle(0, 1, 0, PC_IDLE, 0, 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout exceeded");
    $fatal(1);
  end

  initial begin
    int r, ack;
    RST_N = 1'b0;
    instr_valid = 1'b0;
    op = OP_ALU;
    cond = 1'b0;
    dm_ack = 1'b0;
    resume = 1'b0;
    do_reset(2);

    // Reset state, then three back-to-back ALU instructions.
    idle_cycle();
    for (int i = 0; i < 3; i++) run_instr(OP_ALU, 1'b0, 0, 0, 0);
    check_int("pc_after_3_alu", inc_obs, 3);

    run_instr(OP_JCC, 1'b1, 0, 0, 0);
    run_instr(OP_JCC, 1'b0, 0, 0, 0);
    run_instr(OP_JMP, 1'b0, 1, 0, 0);
    run_instr(OP_JMPR, 1'b0, 0, 0, 0);
    run_instr(OP_RET, 1'b0, 0, 4, 0);
    run_instr(OP_RET, 1'b0, 0, 1, 0);
    run_instr(OP_RET, 1'b0, 0, WD, 0);
    run_instr(OP_RET, 1'b0, 0, 0, 0);
    run_instr(OP_HALT, 1'b0, 0, 0, 1);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of a return wait.
    instr_valid = 1'b1;
    op = OP_RET;
    expect_cycle(1, 0, 0, PC_IDLE, 0, 0);
    expect_cycle(0, 0, 0, PC_IDLE, 0, 0);
    instr_valid = 1'b0;
    dm_ack = 1'b0;
    expect_cycle(0, 0, 0, PC_IDLE, 1, 0);
    expect_cycle(0, 0, 0, PC_IDLE, 1, 0);
    do_reset(1);
    instr_valid = 1'b0;
    op = OP_ALU;
    dm_ack = 1'b0;
    resume = 1'b0;
    expect_cycle(0, 0, 0, PC_IDLE, 0, 0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 17);
      ack = (r < 15) ? r + 1 : 0;
      run_instr(3'($urandom), 1'($urandom), $urandom_range(0, 2), ack, $urandom_range(0, 3));
    end
    idle_cycle();

    check_int("queue_drained", exp_q.size(), 0);
    check_int("inc_pulses_total", inc_obs, inc_m);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
